mat_serializer: RTL and testbench



---
 rtl/mat_serializer_if.sv | 33 +++
 rtl/mat_serializer.sv | 111 +++++++++++
 tb/tb_mat_serializer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_serializer_if.sv
// Handshake bundle for mat_serializer: whole-matrix capture on the in side,
// one element per beat on the out side.
interface mat_serializer_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
);
  localparam int W  = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*COLS*W-1:0] in_mat;
  logic                   out_valid;
  logic                   out_ready;
  logic [W-1:0]           out_data;
  logic [RW-1:0]          out_row;
  logic [CW-1:0]          out_col;
  logic                   out_last_col;
  logic                   out_last;

  modport master (
    output in_valid, in_mat, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last_col, out_last
  );

  modport slave (
    input  in_valid, in_mat, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last_col, out_last
  );
endinterface

// File: rtl/mat_serializer.sv
// Single-buffered matrix-to-stream serializer: captures a flattened ROWS x COLS
// matrix, then emits it row-major, one bit-exact element per handshake beat.
//
//   state | meaning
//   IDLE  | buffer empty, in_ready=1, out_valid=0
//   SEND  | streaming buffer element (row, col), out_valid=1
module mat_serializer #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int BIAS       = 127,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mat_serializer_if.slave  bus
);
  localparam int W  = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int N  = ROWS * COLS;
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  if (ROWS < 1 || COLS < 1 || BIAS < 0 || BIAS >= (1 << EXP_WIDTH)) begin : g_param_check
    $error("mat_serializer: ROWS/COLS must be >= 1 and BIAS must fit the exponent field");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N*W-1:0]  mat_q;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [31:0]     sel;
  logic [W-1:0]    elem;
  logic            out_valid;
  logic            in_ready;
  logic            last_col;
  logic            last;
  logic            beat;
  logic            capture;

  assign out_valid = (state_q == SEND);
  assign last_col  = (col_q == COL_MAX);
  assign last      = last_col && (row_q == ROW_MAX);
  assign beat      = out_valid && bus.out_ready;
  // Reloading on the final beat keeps the stream gap-free between matrices.
  assign in_ready  = (state_q == IDLE) || (beat && last);
  assign capture   = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      if (capture) begin
        mat_q <= bus.in_mat;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (capture) begin
      state_d = SEND;
      row_d   = '0;
      col_d   = '0;
    end else if (beat) begin
      if (last) begin
        state_d = IDLE;
      end
      if (!last_col) begin
        col_d = col_q + 1'b1;
      end else begin
        col_d = '0;
        // Explicit wrap so non-power-of-two ROWS never indexes past the buffer.
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end
    end
  end

  assign sel = 32'(row_q) * 32'(COLS) + 32'(col_q);

  always_comb begin
    elem = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == 32'(i)) begin
        elem = mat_q[i*W +: W];
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = elem;
  assign bus.out_row      = row_q;
  assign bus.out_col      = col_q;
  assign bus.out_last_col = last_col;
  assign bus.out_last     = last;
endmodule

// File: tb/tb_mat_serializer.sv
// Bench for mat_serializer: a 2x3 and a 1x1 instance, a per-cycle vector table
// for the basic/backpressure stream, and a scoreboard model checking every beat.
module tb_mat_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mat_serializer_if #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .ROWS(2), .COLS(3)) ifa ();
  mat_serializer_if #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .ROWS(1), .COLS(1)) ifb ();

  mat_serializer #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .BIAS(127), .ROWS(2), .COLS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  mat_serializer #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .BIAS(127), .ROWS(1), .COLS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  typedef struct {
    logic [31:0] data;
    int          row;
    int          col;
    logic        lc;
    logic        last;
  } beat_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic [31:0] d;
    int          r;
    int          c;
    logic        lc;
    logic        l;
  } vec_t;

  beat_t sb_a[$];
  beat_t sb_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [191:0] mk(input logic [31:0] base);
    logic [191:0] m;
    m = '0;
    for (int n = 0; n < 6; n++) m[n*32 +: 32] = base + 32'(n);
    return m;
  endfunction

  // Reference model: the queue holds the remaining elements of the matrix in flight.
  task automatic model_step(input int k, input int rows, input int cols,
                            input logic iv, input logic [191:0] mat, input logic ir,
                            input logic ov, input logic ordy, input logic [31:0] d,
                            input int r, input int c, input logic lc, input logic l);
    int    depth;
    logic  eir;
    beat_t e;
    depth = (k == 0) ? sb_a.size() : sb_b.size();
    eir = (depth == 0) || (ordy && depth == 1);
    chk($sformatf("u%0d in_ready", k), 32'(ir), 32'(eir));
    chk($sformatf("u%0d out_valid", k), 32'(ov), 32'(depth != 0));
    if (depth != 0 && ordy) begin
      if (k == 0) e = sb_a.pop_front();
      else        e = sb_b.pop_front();
      chk($sformatf("u%0d beat data", k), d, e.data);
      chk($sformatf("u%0d beat row", k), 32'(r), 32'(e.row));
      chk($sformatf("u%0d beat col", k), 32'(c), 32'(e.col));
      chk($sformatf("u%0d beat last_col", k), 32'(lc), 32'(e.lc));
      chk($sformatf("u%0d beat last", k), 32'(l), 32'(e.last));
    end
    if (iv && eir) begin
      for (int rr = 0; rr < rows; rr++) begin
        for (int cc = 0; cc < cols; cc++) begin
          e.data = mat[(rr*cols+cc)*32 +: 32];
          e.row  = rr;
          e.col  = cc;
          e.lc   = (cc == cols - 1);
          e.last = (rr == rows - 1) && (cc == cols - 1);
          if (k == 0) sb_a.push_back(e);
          else        sb_b.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_a.delete();
      sb_b.delete();
    end else begin
      model_step(0, 2, 3, ifa.in_valid, 192'(ifa.in_mat), ifa.in_ready, ifa.out_valid,
                 ifa.out_ready, ifa.out_data, int'(ifa.out_row), int'(ifa.out_col),
                 ifa.out_last_col, ifa.out_last);
      model_step(1, 1, 1, ifb.in_valid, 192'(ifb.in_mat), ifb.in_ready, ifb.out_valid,
                 ifb.out_ready, ifb.out_data, int'(ifb.out_row), int'(ifb.out_col),
                 ifb.out_last_col, ifb.out_last);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[11];
  logic [31:0] vals[6];

  initial begin
    ifa.in_valid = 1'b0; ifa.in_mat = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_mat = '0; ifb.out_ready = 1'b0;

    // basic 2x3 stream with a 3-cycle stall at (0,1)
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h3F800000, 0, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h3F800001, 0, 1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h3F800001, 0, 1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h3F800001, 0, 1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h3F800001, 0, 1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h3F800002, 0, 2, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h3F800003, 1, 0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h3F800004, 1, 1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h3F800005, 1, 2, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h3F800000, 0, 0, 1'b0, 1'b0};

    vals[0] = 32'h7FC00000; vals[1] = 32'h7F800000; vals[2] = 32'hFF800000;
    vals[3] = 32'h00000001; vals[4] = 32'h80000000; vals[5] = 32'h3F800000;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst a out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst a in_ready", 32'(ifa.in_ready), 32'd1);
    chk("rst a out_data", ifa.out_data, 32'h0);
    chk("rst a row/col", {16'(ifa.out_row), 16'(ifa.out_col)}, 32'h0);
    chk("rst a last_col", 32'(ifa.out_last_col), 32'd0);
    chk("rst a last", 32'(ifa.out_last), 32'd0);
    chk("rst b last_col", 32'(ifb.out_last_col), 32'd1);
    chk("rst b last", 32'(ifb.out_last), 32'd1);
    next_cycle();

    ifa.in_mat = mk(32'h3F800000);
    for (int i = 0; i < 11; i++) begin
      ifa.in_valid  = tbl[i].iv;
      ifa.out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl[%0d] out_valid", i), 32'(ifa.out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl[%0d] in_ready", i), 32'(ifa.in_ready), 32'(tbl[i].ir));
      chk($sformatf("tbl[%0d] out_data", i), ifa.out_data, tbl[i].d);
      chk($sformatf("tbl[%0d] out_row", i), 32'(ifa.out_row), 32'(tbl[i].r));
      chk($sformatf("tbl[%0d] out_col", i), 32'(ifa.out_col), 32'(tbl[i].c));
      chk($sformatf("tbl[%0d] last_col", i), 32'(ifa.out_last_col), 32'(tbl[i].lc));
      chk($sformatf("tbl[%0d] last", i), 32'(ifa.out_last), 32'(tbl[i].l));
      next_cycle();
    end

    // back-to-back A then B with in_valid held high
    ifa.in_mat = mk(32'h3F800000); ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    next_cycle();
    ifa.in_mat = mk(32'hC0000000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("b2b out_valid", 32'(ifa.out_valid), 32'd1);
      if (i == 6) chk("b2b B(0,0)", ifa.out_data, 32'hC0000000);
      next_cycle();
      if (i == 5) ifa.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b idle out_valid", 32'(ifa.out_valid), 32'd0);
    next_cycle();

    // pulse in_valid mid-stream; must be ignored
    ifa.in_mat = mk(32'h40000000); ifa.in_valid = 1'b1;
    next_cycle();
    ifa.in_valid = 1'b0; ifa.in_mat = mk(32'h7FC00000);
    next_cycle();
    ifa.in_valid = 1'b1; ifa.in_mat = mk(32'h12345600);
    @(negedge clk);
    chk("ign in_ready", 32'(ifa.in_ready), 32'd0);
    next_cycle();
    ifa.in_valid = 1'b0;
    repeat (6) next_cycle();
    @(negedge clk);
    chk("ign done out_valid", 32'(ifa.out_valid), 32'd0);
    next_cycle();

    // reset in the middle of a stream at element (1,0)
    ifa.in_mat = mk(32'h3F800000); ifa.in_valid = 1'b1;
    next_cycle();
    ifa.in_valid = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rmid pos", {16'(ifa.out_row), 16'(ifa.out_col)}, {16'd1, 16'd0});
    #2 rst_n = 1'b0;
    #1;
    chk("rmid out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rmid out_data", ifa.out_data, 32'h0);
    chk("rmid in_ready", 32'(ifa.in_ready), 32'd1);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmid idle after release", 32'(ifa.out_valid), 32'd0);
    next_cycle();
    ifa.in_mat = mk(32'h00000001); ifa.in_valid = 1'b1;
    next_cycle();
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("rmid restart pos", {16'(ifa.out_row), 16'(ifa.out_col)}, 32'h0);
    chk("rmid restart data", ifa.out_data, 32'h00000001);
    next_cycle();
    repeat (6) next_cycle();

    // 1x1: one matrix per cycle, special float patterns pass untouched
    ifb.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ifb.in_mat    = vals[i];
      ifb.out_ready = (i != 3);
      @(negedge clk);
      if (i > 0) begin
        chk("1x1 out_valid", 32'(ifb.out_valid), 32'd1);
        chk("1x1 last_col", 32'(ifb.out_last_col), 32'd1);
        chk("1x1 last", 32'(ifb.out_last), 32'd1);
      end
      next_cycle();
    end
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;
    @(negedge clk);
    chk("1x1 tail data", ifb.out_data, 32'h3F800000);
    next_cycle();
    @(negedge clk);
    chk("1x1 idle out_valid", 32'(ifb.out_valid), 32'd0);
    next_cycle();

    chk("sb_a drained", 32'(sb_a.size()), 32'd0);
    chk("sb_b drained", 32'(sb_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
